conv_bias_relu: RTL and testbench
=================================

Name: conv_bias_relu

Overview:
- Downstream stage of the first convolution layer: consumes raw 32-bit conv accumulations, adds per-output-channel bias, applies ReLU, then requantizes to OUT_W.
- Owns bias storage: loads NUM_CH biases over the existing biases/vld/rdy stream before it accepts any conv data.
- Output is a valid/ready stream to the pooling/next-conv input loader.

Parameters:
DATA_W, 32, width of conv accumulation and bias words (signed two's complement)
OUT_W, 16, width of the requantized output word (signed)
NUM_CH, 32, output channels; equals the number of kernels in the first conv
NUM_PIX, 16384, output pixels per channel (128x128)
SHIFT, 8, arithmetic right-shift applied before saturation

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
biases  in  DATA_W  bias word, channel order 0..NUM_CH-1
biases_vld  in  1  bias word valid
biases_rdy  out  1  bias word accepted when biases_vld && biases_rdy
conv_data  in  DATA_W  conv result, channel-fastest order (pix0 ch0..ch31, pix1 ch0..)
conv_vld  in  1  conv result valid
conv_rdy  out  1  conv result accepted when conv_vld && conv_rdy
out_data  out  OUT_W  processed result, same order as input
out_vld  out  1  out_data valid
out_rdy  in  1  downstream ready
layer_done  out  1  level, high once the last result has been accepted downstream

Behaviour:
- Reset values: biases_rdy=0, conv_rdy=0, out_vld=0, out_data=0, layer_done=0, state=LOAD_BIAS, bias_cnt=0, ch_cnt=0, pix_cnt=0. Bias RAM contents are not reset.
- Reset asserted mid-operation: abandons the layer and returns to LOAD_BIAS. Biases must be reloaded.
- State LOAD_BIAS: biases_rdy=1, conv_rdy=0.
  - Each handshake writes bias_mem[bias_cnt] and increments bias_cnt.
  - On the handshake with bias_cnt==NUM_CH-1: go to RUN and drop biases_rdy next cycle.
  - No counting without the handshake; data change alone never advances.
- State RUN: biases_rdy=0, conv_rdy = !out_vld || out_rdy. This is a combinational single-register pipeline, and full throughput is 1/cycle.
- On a conv handshake:
  - sum = sext(conv_data) + sext(bias_mem[ch_cnt]), computed at DATA_W+1 bits with no overflow.
  - ReLU: r = (sum<0) ? 0 : sum.
  - q = r >>> SHIFT.
  - Saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Result is registered into out_data with out_vld=1 on the next edge. Latency is 1 cycle.
- Counters: ch_cnt increments per accepted conv beat and wraps from NUM_CH-1 to 0. pix_cnt increments on that wrap.
- On acceptance of beat (pix_cnt==NUM_PIX-1, ch_cnt==NUM_CH-1): go to DRAIN, conv_rdy=0.
- State DRAIN: wait for the out_vld && out_rdy of the final result, then go to DONE.
- State DONE: layer_done=1, all rdy=0, out_vld=0. Holds until reset.
- Output handshake: out_vld stays high with out_data stable until out_rdy is seen. If the downstream handshake and a new input acceptance happen in the same cycle, the register is overwritten with the new result and out_vld stays 1. With no new input, out_vld falls.
- Back-pressure: out_rdy=0 with out_vld=1 forces conv_rdy=0. No data is lost or duplicated.
- conv_vld asserted during LOAD_BIAS is ignored (not acknowledged).

Optional Feature:
- Macro CONV_BIAS_RELU_EN.
- Defined: the ReLU stage is applied as above.
- Undefined: ReLU is bypassed. Negative sums are shifted and saturated symmetrically, so the minimum output is -2^(OUT_W-1). All timing is unchanged.

Decomposition:
- Package conv_pkg holds:
  - constants NUM_CH, NUM_PIX, DATA_W.
  - the state enum typedef post_state_t {LOAD_BIAS, RUN, DRAIN, DONE}.
  - function sat_shift(sum, SHIFT, OUT_W).
- One sub-module, post_sat_unit: a combinational add/ReLU/shift/saturate datapath, instantiated once inside conv_bias_relu. The FSM, counters and bias RAM live in the top module.

Test Plan:
- Bias load with gaps: drive 32 biases with biases_vld toggling every other cycle, including a repeated identical value. Required: exactly 32 words stored, biases_rdy falls after the 32nd handshake, conv_rdy rises the next cycle.
- Arithmetic, SHIFT=8, OUT_W=16, with CONV_BIAS_RELU_EN defined:
  - conv=0x00001000, bias[0]=0x00000100 -> out=0x0011.
  - conv=-5000, bias[1]=100 -> out=0.
  - conv=0x7FFFFFFF, bias[2]=1 -> out=0x7FFF (no wrap).
- Macro undefined: conv=-2^31, bias=-1 -> out=0x8000; conv=-5000, bias=100 -> out=-20.
- Back-pressure: hold out_rdy=0 for 10 cycles during continuous conv_vld. Required: conv_rdy=0 after one accepted beat, out_data stable throughout. On out_rdy=1 the stream resumes in order with no duplicates.
- Full layer, NUM_PIX=4 override: 128 beats with random out_rdy. Required: ch index wraps 31->0 four times, DRAIN then layer_done=1 one cycle after the final output handshake, conv_rdy stays 0 afterwards.
- Mid-run reset after 50 conv beats. Required: all outputs return to reset values the next cycle, state is LOAD_BIAS, and a full bias reload is needed before conv_rdy=1.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types, default sizes and the shift/saturate helper for the
// conv bias + ReLU + requantize stage.
package conv_pkg;

   localparam int DATA_W  = 32;
   localparam int OUT_W   = 16;
   localparam int NUM_CH  = 32;
   localparam int NUM_PIX = 16384;
   localparam int SHIFT   = 8;

   typedef enum logic [1:0] {
      LOAD_BIAS,
      RUN,
      DRAIN,
      DONE
   } post_state_t;

   // Arithmetic right shift of a DATA_W+1 bit sum, clamped to a signed
   // out_w-bit range. The result stays DATA_W+1 wide; callers narrow it.
   function automatic logic signed [DATA_W:0] sat_shift(
      input logic signed [DATA_W:0] sum,
      input int                     shift,
      input int                     out_w
   );
      logic signed [DATA_W:0] q;
      logic signed [DATA_W:0] hi;
      logic signed [DATA_W:0] lo;
      logic signed [DATA_W:0] one;
      one = 1;
      q   = sum >>> shift;
      hi  = (one <<< (out_w - 1)) - one;
      lo  = ~hi;
      if (q > hi) begin
         return hi;
      end else if (q < lo) begin
         return lo;
      end else begin
         return q;
      end
   endfunction

endpackage

// File: rtl/post_sat_unit.sv
// Combinational add-bias / ReLU / shift / saturate datapath.
// ReLU is applied only when CONV_BIAS_RELU_EN is defined.
module post_sat_unit
   import conv_pkg::*;
#(
   parameter int DATA_W = conv_pkg::DATA_W,
   parameter int OUT_W  = conv_pkg::OUT_W,
   parameter int SHIFT  = conv_pkg::SHIFT
) (
   input  logic [DATA_W-1:0] i_conv,
   input  logic [DATA_W-1:0] i_bias,
   output logic [OUT_W-1:0]  o_result
);

   logic signed [DATA_W:0] w_sum;
   logic signed [DATA_W:0] w_act;
   logic signed [DATA_W:0] w_sat;

   // One extra bit of headroom so the add can never overflow.
   assign w_sum = $signed({i_conv[DATA_W-1], i_conv}) + $signed({i_bias[DATA_W-1], i_bias});

`ifdef CONV_BIAS_RELU_EN
   assign w_act = w_sum[DATA_W] ? '0 : w_sum;
`else
   assign w_act = w_sum;
`endif

   assign w_sat    = sat_shift(w_act, SHIFT, OUT_W);
   assign o_result = OUT_W'(w_sat);

endmodule

// File: rtl/conv_bias_relu.sv
// Bias load, per-channel bias add, optional ReLU (CONV_BIAS_RELU_EN) and
// requantization of first-layer conv accumulations, with a one-register output.
module conv_bias_relu
   import conv_pkg::*;
#(
   parameter int DATA_W  = conv_pkg::DATA_W,
   parameter int OUT_W   = conv_pkg::OUT_W,
   parameter int NUM_CH  = conv_pkg::NUM_CH,
   parameter int NUM_PIX = conv_pkg::NUM_PIX,
   parameter int SHIFT   = conv_pkg::SHIFT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] biases,
   input  logic              biases_vld,
   output logic              biases_rdy,
   input  logic [DATA_W-1:0] conv_data,
   input  logic              conv_vld,
   output logic              conv_rdy,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic              layer_done,
   output post_state_t       o_dbg_state
);

   localparam int CH_W  = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1;
   localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIX - 1);

   post_state_t       r_state;
   post_state_t       w_next_state;
   logic [CH_W-1:0]   r_bias_cnt;
   logic [CH_W-1:0]   r_ch_cnt;
   logic [PIX_W-1:0]  r_pix_cnt;
   logic [DATA_W-1:0] r_bias_mem [NUM_CH];
   logic              r_biases_rdy;
   logic              r_out_vld;
   logic [OUT_W-1:0]  r_out_data;

   logic              w_bias_hs;
   logic              w_conv_rdy;
   logic              w_conv_hs;
   logic              w_out_hs;
   logic              w_last_beat;
   logic              w_layer_done;
   logic [OUT_W-1:0]  w_result;

   // Handshakes: a beat moves on a rising edge where vld && rdy; vld holds its
   // data until taken, rdy never depends on vld.
   assign w_bias_hs   = biases_vld && r_biases_rdy;
   assign w_conv_hs   = conv_vld && w_conv_rdy;
   assign w_out_hs    = r_out_vld && out_rdy;
   assign w_last_beat = (r_ch_cnt == LAST_CH) && (r_pix_cnt == LAST_PIX);

   post_sat_unit #(
      .DATA_W (DATA_W),
      .OUT_W  (OUT_W),
      .SHIFT  (SHIFT)
   ) u_post_sat (
      .i_conv   (conv_data),
      .i_bias   (r_bias_mem[r_ch_cnt]),
      .o_result (w_result)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= LOAD_BIAS;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_conv_rdy   = 1'b0;
      w_layer_done = 1'b0;
      case (r_state)
         LOAD_BIAS: begin
            if (w_bias_hs && (r_bias_cnt == LAST_CH)) begin
               w_next_state = RUN;
            end
         end
         RUN: begin
            // Accept when the output register is empty or being emptied now.
            w_conv_rdy = !r_out_vld || out_rdy;
            if (conv_vld && w_conv_rdy && w_last_beat) begin
               w_next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (w_out_hs) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            w_layer_done = 1'b1;
         end
         default: begin
            w_next_state = LOAD_BIAS;
         end
      endcase
   end

   // Bias RAM is deliberately not reset; it is always reloaded before use.
   always_ff @(posedge clk) begin
      if (w_bias_hs) begin
         r_bias_mem[r_bias_cnt] <= biases;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bias_cnt   <= '0;
         r_biases_rdy <= 1'b0;
      end else begin
         r_biases_rdy <= (w_next_state == LOAD_BIAS);
         if (w_bias_hs) begin
            r_bias_cnt <= (r_bias_cnt == LAST_CH) ? '0 : r_bias_cnt + CH_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ch_cnt  <= '0;
         r_pix_cnt <= '0;
      end else if (w_conv_hs) begin
         if (r_ch_cnt == LAST_CH) begin
            r_ch_cnt  <= '0;
            r_pix_cnt <= (r_pix_cnt == LAST_PIX) ? '0 : r_pix_cnt + PIX_W'(1);
         end else begin
            r_ch_cnt <= r_ch_cnt + CH_W'(1);
         end
      end
   end

   // A new result may overwrite the register in the same cycle it is drained.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_vld  <= 1'b0;
         r_out_data <= '0;
      end else if (w_conv_hs) begin
         r_out_vld  <= 1'b1;
         r_out_data <= w_result;
      end else if (w_out_hs) begin
         r_out_vld <= 1'b0;
      end
   end

   assign biases_rdy  = r_biases_rdy;
   assign conv_rdy    = w_conv_rdy;
   assign out_vld     = r_out_vld;
   assign out_data    = r_out_data;
   assign layer_done  = w_layer_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv_bias_relu.sv
// Scoreboard bench for conv_bias_relu with a 4-pixel layer: bias load,
// arithmetic corners, back-pressure, mid-run reset and a full layer.
module tb_conv_bias_relu;
  import conv_pkg::*;

  localparam int TB_NUM_PIX = 4;
  localparam int TB_NUM_CH  = 32;
  localparam int LAYER_BEATS = TB_NUM_PIX * TB_NUM_CH;

  logic        clk;
  logic        reset;
  logic [31:0] biases;
  logic        biases_vld;
  logic        biases_rdy;
  logic [31:0] conv_data;
  logic        conv_vld;
  logic        conv_rdy;
  logic [15:0] out_data;
  logic        out_vld;
  logic        out_rdy;
  logic        layer_done;
  post_state_t dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  logic signed [31:0] bias_model [TB_NUM_CH];
  int beat_idx = 0;
  int out_seen = 0;
  int rdy_mode = 0;

  conv_bias_relu #(
    .NUM_PIX (TB_NUM_PIX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .biases      (biases),
    .biases_vld  (biases_vld),
    .biases_rdy  (biases_rdy),
    .conv_data   (conv_data),
    .conv_vld    (conv_vld),
    .conv_rdy    (conv_rdy),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .layer_done  (layer_done),
    .o_dbg_state (dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: signed sum, optional clamp at zero, floor-divide by 256, clip to int16.
  function automatic logic [15:0] model(input logic [31:0] c, input logic signed [31:0] b);
    longint s;
    s = longint'($signed(c)) + longint'(b);
`ifdef CONV_BIAS_RELU_EN
    if (s < 0) s = 0;
`endif
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  function automatic logic [31:0] rand_conv();
    if ($urandom_range(0, 1) == 1) return $urandom();
    return 32'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
  endfunction

  // out_rdy driver: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    out_rdy = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: out_rdy = 1'b1;
        1: out_rdy = 1'($urandom_range(0, 1));
        default: out_rdy = 1'b0;
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!reset && out_vld && out_rdy) begin
        out_seen++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL out_unexpected: got %0h required no output", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    conv_vld  = 1'b1;
    conv_data = d;
    #1;
    while (!conv_rdy && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!conv_rdy) begin
      chk("conv_accept_timeout", 32'(conv_rdy), 32'd1);
    end else begin
      exp_q.push_back(model(d, bias_model[beat_idx % TB_NUM_CH]));
      beat_idx++;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    conv_vld = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_biases_rdy"}, 32'(biases_rdy), 32'd0);
    chk({tag, "_conv_rdy"}, 32'(conv_rdy), 32'd0);
    chk({tag, "_out_vld"}, 32'(out_vld), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_layer_done"}, 32'(layer_done), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(LOAD_BIAS));
  endtask

  // Biases go in with the valid toggling every other cycle; data wiggles in gaps.
  task automatic load_biases();
    int waited;
    for (int i = 0; i < TB_NUM_CH; i++) begin
      @(negedge clk);
      biases_vld = 1'b1;
      biases     = bias_model[i];
      #1;
      waited = 0;
      while (!biases_rdy && waited < 50) begin
        @(negedge clk);
        #1;
        waited++;
      end
      if (!biases_rdy) chk("bias_accept_timeout", 32'(biases_rdy), 32'd1);
      if (i == 16) chk("bias_conv_rdy_low", 32'(conv_rdy), 32'd0);
      @(negedge clk);
      biases_vld = 1'b0;
      biases     = $urandom();
      #1;
      if (i < TB_NUM_CH - 1) chk("bias_rdy_held", 32'(biases_rdy), 32'd1);
    end
    chk("bias_rdy_fall", 32'(biases_rdy), 32'd0);
    chk("conv_rdy_rise", 32'(conv_rdy), 32'd1);
    chk("state_run", 32'(dbg_state), 32'(RUN));
  endtask

  task automatic random_biases();
    for (int i = 0; i < TB_NUM_CH; i++) begin
      bias_model[i] = 32'($urandom_range(0, 32'h3FFFF)) - 32'sh20000;
    end
  endtask

  initial begin
    logic [31:0] d1;
    logic [31:0] d2;
    logic [15:0] held;
    int waited;

    reset = 1'b1;
    biases = '0;
    biases_vld = 1'b0;
    conv_data = '0;
    conv_vld = 1'b0;
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("init");
    reset = 1'b0;

    // conv data offered before biases exist must be ignored
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      conv_vld = 1'b1;
      conv_data = $urandom();
      #1;
      chk("early_conv_ignored", 32'(conv_rdy), 32'd0);
    end
    @(negedge clk);
    conv_vld = 1'b0;

    random_biases();
    bias_model[0] = 32'sh100;
    bias_model[1] = 32'sd100;
    bias_model[2] = 32'sd1;
    bias_model[3] = -32'sd1;
    bias_model[4] = 32'sd100;
    bias_model[5] = 32'sd100;
    load_biases();

    // arithmetic corners
    send_beat(32'h0000_1000);
    send_beat(-32'sd5000);
    send_beat(32'h7FFF_FFFF);
    send_beat(32'h8000_0000);
    send_beat(-32'sd5000);

    rdy_mode = 1;
    while (beat_idx < 40) begin
      send_beat(rand_conv());
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // back-pressure: empty the output register, then stall the downstream
    idle_cycle();
    rdy_mode = 0;
    waited = 0;
    while ((out_vld || exp_q.size() != 0) && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("bp_drained", 32'(out_vld), 32'd0);
    rdy_mode = 2;
    d1 = rand_conv();
    d2 = rand_conv();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      conv_vld  = 1'b1;
      conv_data = (k == 0) ? d1 : d2;
      #1;
      if (k == 0) begin
        chk("bp_first_accept", 32'(conv_rdy), 32'd1);
        exp_q.push_back(model(d1, bias_model[beat_idx % TB_NUM_CH]));
        beat_idx++;
      end else begin
        chk("bp_stall", 32'(conv_rdy), 32'd0);
        chk("bp_out_vld", 32'(out_vld), 32'd1);
        if (k == 1) held = out_data;
        else chk("bp_hold", 32'(out_data), 32'(held));
      end
    end
    rdy_mode = 0;
    send_beat(d2);
    while (beat_idx < 50) send_beat(rand_conv());

    // mid-run reset
    @(negedge clk);
    conv_vld = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    check_reset_values("midrst");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      conv_vld = 1'b1;
      conv_data = $urandom();
      #1;
      chk("midrst_conv_blocked", 32'(conv_rdy), 32'd0);
    end
    @(negedge clk);
    conv_vld = 1'b0;

    // full layer after reload
    random_biases();
    load_biases();
    beat_idx = 0;
    out_seen = 0;
    rdy_mode = 1;
    while (beat_idx < LAYER_BEATS) begin
      send_beat(rand_conv());
      if ($urandom_range(0, 3) == 0 && beat_idx < LAYER_BEATS) idle_cycle();
    end
    @(negedge clk);
    conv_vld = 1'b0;
    #1;
    chk("drain_state", 32'(dbg_state), 32'(DRAIN));
    chk("drain_conv_rdy", 32'(conv_rdy), 32'd0);
    chk("drain_not_done", 32'(layer_done), 32'd0);
    #2;
    waited = 0;
    while (!(out_vld && out_rdy) && waited < 100) begin
      @(negedge clk);
      #3;
      waited++;
    end
    chk("final_handshake_seen", 32'(out_vld && out_rdy), 32'd1);
    @(negedge clk);
    #3;
    chk("done_layer_done", 32'(layer_done), 32'd1);
    chk("done_state", 32'(dbg_state), 32'(DONE));
    chk("done_out_vld", 32'(out_vld), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      conv_vld = 1'b1;
      conv_data = $urandom();
      #1;
      chk("done_conv_rdy", 32'(conv_rdy), 32'd0);
      chk("done_held", 32'(layer_done), 32'd1);
    end
    conv_vld = 1'b0;
    chk("layer_out_count", 32'(out_seen), 32'(LAYER_BEATS));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
